// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared encodings for the memory stage.
// Store types, FSM states, exception bit positions, load-control fields,
// the MEM_WB register layout and the misalignment rule used when
// MEM_ADDR_EXC_EN is defined.
package memory_stage_pkg;

    typedef enum logic [2:0] {
        ST_SB  = 3'd0,
        ST_SH  = 3'd1,
        ST_SW  = 3'd2,
        ST_SWL = 3'd3,
        ST_SWR = 3'd4
    } st_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam int EX_ADEL = 0;
    localparam int EX_ADES = 1;

    // LdCtl = {LW[1:0], LB, LBU, LH, LHU}; LW field 2'b01 is a plain word load
    localparam int LD_LH  = 1;
    localparam int LD_LHU = 0;
    localparam logic [1:0] LW_WORD = 2'b01;

    typedef struct packed {
        logic        valid;
        logic [31:0] mem_rdata;
        logic [31:0] alu_result;
        logic [31:0] rt;
        logic [5:0]  ld_ctl;
        logic [4:0]  waddr;
        logic [3:0]  reg_write;
        logic [31:0] pc;
        logic [1:0]  ex;
        logic [31:0] bad_vaddr;
    } mem_wb_t;

    // Halfword accesses need a[0]=0, word accesses need a=0
    function automatic logic misaligned(input logic wr, input logic [2:0] st,
                                        input logic [5:0] ld, input logic [1:0] a);
        return wr ? ((st == ST_SH && a[0]) || (st == ST_SW && a != 2'b00))
                  : (((ld[LD_LH] || ld[LD_LHU]) && a[0]) || (ld[5:4] == LW_WORD && a != 2'b00));
    endfunction

endpackage

// File: rtl/memory_stage_store_align.sv
// store_align: byte strobes and lane-aligned write data for a store.
// Ports: st_type (store kind), a (address low bits), rt (store source)
//        -> wstrb (byte enables), wdata (bus write data). Combinational.
module store_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  st_type,
    input  logic [1:0]  a,
    input  logic [31:0] rt,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    always_comb begin
        wstrb = 4'b0000;
        wdata = rt;
        case (st_type)
            ST_SB: begin
                wstrb = 4'b0001 << a;
                wdata = {4{rt[7:0]}};
            end
            ST_SH: begin
                wstrb = a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rt[15:0]}};
            end
            ST_SW:  wstrb = 4'b1111;
            // SWL writes the top (a+1) bytes of rt into the low lanes
            ST_SWL: begin
                wstrb = 4'b1111 >> ~a;
                wdata = rt >> {~a, 3'b000};
            end
            // SWR writes the low (4-a) bytes of rt into the high lanes
            ST_SWR: begin
                wstrb = 4'b1111 << a;
                wdata = rt << {a, 3'b000};
            end
            default: wstrb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage with a req/addr_ok/data_ok data-bus FSM.
// Inputs:  clk, rst, EXE_MEM fields (valid, MemEn, MemWr, StType, LdCtl,
//          ALUResult, RegRdata2, RegWaddr, RegWrite, PC), data bus handshake
//          (data_addr_ok, data_data_ok, data_rdata).
// Outputs: data bus request (data_req, data_wr, data_wstrb, data_addr,
//          data_wdata), Stall_MEM, registered MEM_WB fields, ex_MEM_WB,
//          BadVAddr_MEM_WB.
// Option:  MEM_ADDR_EXC_EN raises AdEL/AdES on misaligned half/word accesses.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_EXE_MEM,
    input  logic        MemEn_EXE_MEM,
    input  logic        MemWr_EXE_MEM,
    input  logic [2:0]  StType_EXE_MEM,
    input  logic [5:0]  LdCtl_EXE_MEM,
    input  logic [31:0] ALUResult_EXE_MEM,
    input  logic [31:0] RegRdata2_EXE_MEM,
    input  logic [4:0]  RegWaddr_EXE_MEM,
    input  logic [3:0]  RegWrite_EXE_MEM,
    input  logic [31:0] PC_EXE_MEM,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        Stall_MEM,
    output logic        valid_MEM_WB,
    output logic [31:0] MemRdata_MEM_WB,
    output logic [31:0] ALUResult_MEM_WB,
    output logic [31:0] RegRdata2_MEM_WB,
    output logic [5:0]  LdCtl_MEM_WB,
    output logic [4:0]  RegWaddr_MEM_WB,
    output logic [3:0]  RegWrite_MEM_WB,
    output logic [31:0] PC_MEM_WB,
    output logic [1:0]  ex_MEM_WB,
    output logic [31:0] BadVAddr_MEM_WB
);

    state_e      state_q, state_d;
    mem_wb_t     mem_wb_q, mem_wb_d;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic        exc, mem_op, done;

`ifdef MEM_ADDR_EXC_EN
    assign exc = valid_EXE_MEM & MemEn_EXE_MEM &
                 misaligned(MemWr_EXE_MEM, StType_EXE_MEM, LdCtl_EXE_MEM, ALUResult_EXE_MEM[1:0]);
`else
    assign exc = 1'b0;
`endif

    // A faulting access never reaches the bus
    assign mem_op = valid_EXE_MEM & MemEn_EXE_MEM & ~exc;
    assign done   = (state_q == S_WAIT) & data_data_ok;

    store_align u_store_align (
        .st_type (StType_EXE_MEM),
        .a       (ALUResult_EXE_MEM[1:0]),
        .rt      (RegRdata2_EXE_MEM),
        .wstrb   (st_wstrb),
        .wdata   (st_wdata)
    );

    always_comb begin
        data_req   = ~rst & ((state_q == S_REQ) | ((state_q == S_IDLE) & mem_op));
        Stall_MEM  = ~rst & mem_op & ~done;
        data_wr    = MemWr_EXE_MEM;
        data_addr  = {ALUResult_EXE_MEM[31:2], 2'b00};
        data_wstrb = MemWr_EXE_MEM ? st_wstrb : 4'b0000;
        data_wdata = st_wdata;
        state_d    = state_q;
        case (state_q)
            S_IDLE:  state_d = (data_req & data_addr_ok) ? S_WAIT : (mem_op ? S_REQ : S_IDLE);
            S_REQ:   state_d = data_addr_ok ? S_WAIT : S_REQ;
            S_WAIT:  state_d = data_data_ok ? S_IDLE : S_WAIT;
            default: state_d = S_IDLE;
        endcase
        mem_wb_d            = mem_wb_q;
        mem_wb_d.valid      = valid_EXE_MEM & ~Stall_MEM;
        mem_wb_d.mem_rdata  = done ? data_rdata : mem_wb_q.mem_rdata;
        mem_wb_d.alu_result = ALUResult_EXE_MEM;
        mem_wb_d.rt         = RegRdata2_EXE_MEM;
        mem_wb_d.ld_ctl     = LdCtl_EXE_MEM;
        mem_wb_d.waddr      = RegWaddr_EXE_MEM;
        mem_wb_d.reg_write  = (Stall_MEM | exc) ? 4'b0000 : RegWrite_EXE_MEM;
        mem_wb_d.pc         = PC_EXE_MEM;
        mem_wb_d.ex         = 2'b00;
        mem_wb_d.ex[EX_ADES] = exc & MemWr_EXE_MEM;
        mem_wb_d.ex[EX_ADEL] = exc & ~MemWr_EXE_MEM;
        mem_wb_d.bad_vaddr  = exc ? ALUResult_EXE_MEM : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mem_wb_q <= '0;
        end else begin
            state_q  <= state_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign valid_MEM_WB     = mem_wb_q.valid;
    assign MemRdata_MEM_WB  = mem_wb_q.mem_rdata;
    assign ALUResult_MEM_WB = mem_wb_q.alu_result;
    assign RegRdata2_MEM_WB = mem_wb_q.rt;
    assign LdCtl_MEM_WB     = mem_wb_q.ld_ctl;
    assign RegWaddr_MEM_WB  = mem_wb_q.waddr;
    assign RegWrite_MEM_WB  = mem_wb_q.reg_write;
    assign PC_MEM_WB        = mem_wb_q.pc;
    assign ex_MEM_WB        = mem_wb_q.ex;
    assign BadVAddr_MEM_WB  = mem_wb_q.bad_vaddr;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized self-checking bench for memory_stage.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_EXE_MEM, MemEn_EXE_MEM, MemWr_EXE_MEM;
    logic [2:0]  StType_EXE_MEM;
    logic [5:0]  LdCtl_EXE_MEM;
    logic [31:0] ALUResult_EXE_MEM, RegRdata2_EXE_MEM, PC_EXE_MEM;
    logic [4:0]  RegWaddr_EXE_MEM;
    logic [3:0]  RegWrite_EXE_MEM;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        Stall_MEM, valid_MEM_WB;
    logic [31:0] MemRdata_MEM_WB, ALUResult_MEM_WB, RegRdata2_MEM_WB, PC_MEM_WB, BadVAddr_MEM_WB;
    logic [5:0]  LdCtl_MEM_WB;
    logic [4:0]  RegWaddr_MEM_WB;
    logic [3:0]  RegWrite_MEM_WB;
    logic [1:0]  ex_MEM_WB;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rdata = 32'h0;
    logic [3:0]  last_strb;
    logic [31:0] last_wdata, last_addr;
    logic        last_wr;

    localparam logic [5:0] LD_LW = 6'b010000;
    localparam logic [5:0] LD_LB = 6'b001000;

    memory_stage dut (
        .clk(clk), .rst(rst),
        .valid_EXE_MEM(valid_EXE_MEM), .MemEn_EXE_MEM(MemEn_EXE_MEM), .MemWr_EXE_MEM(MemWr_EXE_MEM),
        .StType_EXE_MEM(StType_EXE_MEM), .LdCtl_EXE_MEM(LdCtl_EXE_MEM),
        .ALUResult_EXE_MEM(ALUResult_EXE_MEM), .RegRdata2_EXE_MEM(RegRdata2_EXE_MEM),
        .RegWaddr_EXE_MEM(RegWaddr_EXE_MEM), .RegWrite_EXE_MEM(RegWrite_EXE_MEM), .PC_EXE_MEM(PC_EXE_MEM),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .Stall_MEM(Stall_MEM), .valid_MEM_WB(valid_MEM_WB),
        .MemRdata_MEM_WB(MemRdata_MEM_WB), .ALUResult_MEM_WB(ALUResult_MEM_WB),
        .RegRdata2_MEM_WB(RegRdata2_MEM_WB), .LdCtl_MEM_WB(LdCtl_MEM_WB),
        .RegWaddr_MEM_WB(RegWaddr_MEM_WB), .RegWrite_MEM_WB(RegWrite_MEM_WB), .PC_MEM_WB(PC_MEM_WB),
        .ex_MEM_WB(ex_MEM_WB), .BadVAddr_MEM_WB(BadVAddr_MEM_WB)
    );

    always #5 clk = ~clk;

    // Reference byte-lane model: which lanes are written and which rt byte lands in each
    function automatic logic [3:0] m_strb(input logic wr, input logic [2:0] st, input logic [1:0] a);
        logic [3:0] s = 4'b0000;
        int ai = int'(a);
        if (!wr) return 4'b0000;
        for (int i = 0; i < 4; i++)
            case (st)
                3'd0: s[i] = (i == ai);
                3'd1: s[i] = (i / 2 == ai / 2);
                3'd2: s[i] = 1'b1;
                3'd3: s[i] = (i <= ai);
                3'd4: s[i] = (i >= ai);
                default: s[i] = 1'b0;
            endcase
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] st, input logic [1:0] a, input logic [31:0] rt);
        logic [31:0] w = 32'h0;
        int ai = int'(a);
        int k;
        for (int i = 0; i < 4; i++) begin
            case (st)
                3'd0: k = 0;
                3'd1: k = i % 2;
                3'd3: k = i + 3 - ai;
                3'd4: k = i - ai;
                default: k = i;
            endcase
            if (k >= 0 && k <= 3) w[8*i +: 8] = rt[8*k +: 8];
        end
        return w;
    endfunction

    task automatic set_op(input logic en, input logic wr, input logic [2:0] st, input logic [5:0] ld,
                          input logic [31:0] addr, input logic [31:0] rt);
        valid_EXE_MEM     = 1'b1;
        MemEn_EXE_MEM     = en;
        MemWr_EXE_MEM     = wr;
        StType_EXE_MEM    = st;
        LdCtl_EXE_MEM     = ld;
        ALUResult_EXE_MEM = addr;
        RegRdata2_EXE_MEM = rt;
        RegWaddr_EXE_MEM  = 5'($urandom);
        RegWrite_EXE_MEM  = 4'($urandom_range(1, 15));
        PC_EXE_MEM        = $urandom;
    endtask

    task automatic bubble();
        valid_EXE_MEM = 1'b0;
        MemEn_EXE_MEM = 1'b0;
    endtask

    // Runs the held memory op: addr_ok after aw wait cycles, data_ok dw cycles after that
    task automatic run_txn(input string nm, input int aw, input int dw, input logic [31:0] rd);
        int reqs = 0, stalls = 0, vhigh = 0;
        bit fin = 0, attr_bad = 0;
        logic [3:0]  rw = RegWrite_EXE_MEM;
        logic [31:0] pc = PC_EXE_MEM, alu = ALUResult_EXE_MEM;
        for (int c = 0; c < 40 && !fin; c++) begin
            data_addr_ok = (c == aw);
            data_data_ok = (c == aw + 1 + dw);
            data_rdata   = (c == aw + 1 + dw) ? rd : $urandom;
            #1;
            if (c == 0) begin
                last_strb = data_wstrb; last_wdata = data_wdata; last_addr = data_addr; last_wr = data_wr;
            end else if (data_req && (data_wstrb !== last_strb || data_wdata !== last_wdata ||
                                      data_addr !== last_addr || data_wr !== last_wr))
                attr_bad = 1;
            reqs   += int'(data_req);
            stalls += int'(Stall_MEM);
            if (c > 0 && valid_MEM_WB) vhigh++;
            fin = !Stall_MEM;
            @(negedge clk);
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        exp_rdata = rd;
        n_tests++; if (!fin) begin n_fail++; $display("FAIL %s timeout: stall never dropped", nm); end
        n_tests++; if (reqs != aw + 1) begin n_fail++; $display("FAIL %s req_cycles got %0d exp %0d", nm, reqs, aw + 1); end
        n_tests++; if (stalls != aw + 1 + dw) begin n_fail++; $display("FAIL %s stall_cycles got %0d exp %0d", nm, stalls, aw + 1 + dw); end
        n_tests++; if (attr_bad) begin n_fail++; $display("FAIL %s attributes changed while req held got 1 exp 0", nm); end
        n_tests++; if (vhigh != 0) begin n_fail++; $display("FAIL %s valid_MEM_WB during stall got %0d exp 0", nm, vhigh); end
        n_tests++; if (valid_MEM_WB !== 1'b1) begin n_fail++; $display("FAIL %s valid_MEM_WB got %b exp 1", nm, valid_MEM_WB); end
        n_tests++; if (MemRdata_MEM_WB !== rd) begin n_fail++; $display("FAIL %s MemRdata got %h exp %h", nm, MemRdata_MEM_WB, rd); end
        n_tests++; if (RegWrite_MEM_WB !== rw) begin n_fail++; $display("FAIL %s RegWrite got %h exp %h", nm, RegWrite_MEM_WB, rw); end
        n_tests++; if (PC_MEM_WB !== pc || ALUResult_MEM_WB !== alu) begin
            n_fail++; $display("FAIL %s PC/ALU got %h/%h exp %h/%h", nm, PC_MEM_WB, ALUResult_MEM_WB, pc, alu);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_op(1'b1, 1'b0, 3'd0, LD_LW, 32'h100, 32'h0);
        data_addr_ok = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        n_tests++; if (data_req !== 1'b0 || Stall_MEM !== 1'b0) begin n_fail++; $display("FAIL reset req/stall got %b/%b exp 0/0", data_req, Stall_MEM); end
        n_tests++; if (valid_MEM_WB !== 1'b0 || RegWrite_MEM_WB !== 4'h0 || MemRdata_MEM_WB !== 32'h0) begin
            n_fail++; $display("FAIL reset mem_wb got v=%b rw=%h rd=%h exp 0", valid_MEM_WB, RegWrite_MEM_WB, MemRdata_MEM_WB);
        end
        n_tests++; if (ex_MEM_WB !== 2'b00 || BadVAddr_MEM_WB !== 32'h0 || PC_MEM_WB !== 32'h0) begin
            n_fail++; $display("FAIL reset ex/badv/pc got %b/%h/%h exp 0", ex_MEM_WB, BadVAddr_MEM_WB, PC_MEM_WB);
        end
        data_addr_ok = 1'b0;
        bubble();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw_basic();
        set_op(1'b1, 1'b0, 3'd0, LD_LW, 32'h100, 32'h0);
        run_txn("lw_basic", 0, 0, 32'hDEADBEEF);
        n_tests++; if (last_addr !== 32'h100 || last_strb !== 4'b0000 || last_wr !== 1'b0) begin
            n_fail++; $display("FAIL lw_basic addr/strb/wr got %h/%b/%b exp 100/0000/0", last_addr, last_strb, last_wr);
        end
        bubble();
    endtask

    task automatic test_sb();
        set_op(1'b1, 1'b1, 3'd0, 6'h0, 32'h103, 32'h000000A5);
        run_txn("sb", 0, $urandom_range(0, 2), $urandom);
        n_tests++; if (last_strb !== 4'b1000 || last_wdata !== 32'hA5A5A5A5 || last_wr !== 1'b1 || last_addr !== 32'h100) begin
            n_fail++; $display("FAIL sb strb/wdata/wr/addr got %b/%h/%b/%h exp 1000/a5a5a5a5/1/100", last_strb, last_wdata, last_wr, last_addr);
        end
        bubble();
    endtask

    task automatic test_swr();
        set_op(1'b1, 1'b1, 3'd4, 6'h0, 32'h201, 32'h11223344);
        run_txn("swr", 1, 0, $urandom);
        n_tests++; if (last_strb !== 4'b1110 || last_wdata !== 32'h22334400) begin
            n_fail++; $display("FAIL swr strb/wdata got %b/%h exp 1110/22334400", last_strb, last_wdata);
        end
        bubble();
    endtask

    task automatic test_addr_ok_delay();
        set_op(1'b1, 1'b1, 3'd2, 6'h0, 32'h400, 32'hCAFEF00D);
        run_txn("addr_delay", 3, $urandom_range(0, 3), $urandom);
        n_tests++; if (last_strb !== 4'b1111 || last_wdata !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL addr_delay strb/wdata got %b/%h exp 1111/cafef00d", last_strb, last_wdata);
        end
        bubble();
    endtask

    task automatic test_non_mem();
        logic [3:0]  rw;
        logic [31:0] alu;
        set_op(1'b0, 1'b0, 3'd0, 6'h0, $urandom, $urandom);
        rw = RegWrite_EXE_MEM; alu = ALUResult_EXE_MEM;
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h5555AAAA;
        #1;
        n_tests++; if (data_req !== 1'b0 || Stall_MEM !== 1'b0) begin n_fail++; $display("FAIL non_mem req/stall got %b/%b exp 0/0", data_req, Stall_MEM); end
        @(negedge clk);
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        n_tests++; if (valid_MEM_WB !== 1'b1 || RegWrite_MEM_WB !== rw || ALUResult_MEM_WB !== alu) begin
            n_fail++; $display("FAIL non_mem wb got v=%b rw=%h alu=%h exp 1/%h/%h", valid_MEM_WB, RegWrite_MEM_WB, ALUResult_MEM_WB, rw, alu);
        end
        n_tests++; if (MemRdata_MEM_WB !== exp_rdata) begin n_fail++; $display("FAIL non_mem stray data_ok captured got %h exp %h", MemRdata_MEM_WB, exp_rdata); end
        bubble();
        @(negedge clk);
    endtask

    task automatic test_rst_in_wait();
        set_op(1'b1, 1'b0, 3'd0, LD_LW, 32'h300, 32'h0);
        data_addr_ok = 1'b1;
        #1;
        n_tests++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL rst_wait req got %b exp 1", data_req); end
        @(negedge clk);
        data_addr_ok = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bubble();
        data_data_ok = 1'b1; data_rdata = 32'hBAD0BAD0;
        #1;
        n_tests++; if (data_req !== 1'b0 || Stall_MEM !== 1'b0) begin n_fail++; $display("FAIL rst_wait req/stall got %b/%b exp 0/0", data_req, Stall_MEM); end
        @(negedge clk);
        data_data_ok = 1'b0;
        exp_rdata = 32'h0;
        n_tests++; if (valid_MEM_WB !== 1'b0 || MemRdata_MEM_WB !== 32'h0) begin
            n_fail++; $display("FAIL rst_wait capture got v=%b rd=%h exp 0/0", valid_MEM_WB, MemRdata_MEM_WB);
        end
        set_op(1'b1, 1'b0, 3'd0, LD_LW, 32'h304, 32'h0);
        run_txn("after_rst", 0, 1, $urandom);
        bubble();
    endtask

    task automatic test_misaligned();
        set_op(1'b1, 1'b0, 3'd0, LD_LW, 32'h102, 32'h0);
`ifdef MEM_ADDR_EXC_EN
        data_addr_ok = 1'b1;
        #1;
        n_tests++; if (data_req !== 1'b0 || Stall_MEM !== 1'b0) begin n_fail++; $display("FAIL misaligned req/stall got %b/%b exp 0/0", data_req, Stall_MEM); end
        @(negedge clk);
        data_addr_ok = 1'b0;
        n_tests++; if (ex_MEM_WB !== 2'b01 || BadVAddr_MEM_WB !== 32'h102 || RegWrite_MEM_WB !== 4'h0 || valid_MEM_WB !== 1'b1) begin
            n_fail++; $display("FAIL misaligned wb got ex=%b badv=%h rw=%h v=%b exp 01/102/0/1", ex_MEM_WB, BadVAddr_MEM_WB, RegWrite_MEM_WB, valid_MEM_WB);
        end
        set_op(1'b1, 1'b1, 3'd1, 6'h0, 32'h205, 32'h0);
        @(negedge clk);
        n_tests++; if (ex_MEM_WB !== 2'b10 || BadVAddr_MEM_WB !== 32'h205) begin
            n_fail++; $display("FAIL misaligned sh got ex=%b badv=%h exp 10/205", ex_MEM_WB, BadVAddr_MEM_WB);
        end
`else
        run_txn("misaligned", 0, 0, 32'h0BADF00D);
        n_tests++; if (last_addr !== 32'h100 || ex_MEM_WB !== 2'b00 || BadVAddr_MEM_WB !== 32'h0) begin
            n_fail++; $display("FAIL misaligned addr/ex/badv got %h/%b/%h exp 100/00/0", last_addr, ex_MEM_WB, BadVAddr_MEM_WB);
        end
`endif
        bubble();
        @(negedge clk);
    endtask

    // Back-to-back random aligned loads and stores with no bubbles between them
    task automatic test_back_to_back();
        for (int n = 0; n < 16; n++) begin
            int k = $urandom_range(0, 5);
            logic [1:0]  a = 2'($urandom);
            logic [31:0] rt = $urandom;
            logic [31:0] addr;
            logic [2:0]  st = 3'(k);
            logic        wr = (k != 5);
            logic [5:0]  ld = 6'h0;
            if (k == 1) a[0] = 1'b0;
            if (k == 2) a = 2'b00;
            if (k == 5) begin
                ld = a[0] ? LD_LB : LD_LW;
                if (ld == LD_LW) a = 2'b00;
                st = 3'd0;
            end
            addr = {$urandom_range(0, 32'h3FFFFFFF), a};
            set_op(1'b1, wr, st, ld, addr, rt);
            run_txn($sformatf("b2b%0d", n), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            n_tests++; if (last_strb !== m_strb(wr, st, a) || (wr && last_wdata !== m_wdata(st, a, rt)) || last_addr !== {addr[31:2], 2'b00}) begin
                n_fail++; $display("FAIL b2b%0d strb/wdata/addr got %b/%h/%h exp %b/%h/%h", n, last_strb, last_wdata, last_addr,
                                   m_strb(wr, st, a), m_wdata(st, a, rt), {addr[31:2], 2'b00});
            end
        end
        bubble();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bubble();
        MemWr_EXE_MEM = 1'b0; StType_EXE_MEM = 3'd0; LdCtl_EXE_MEM = 6'h0;
        ALUResult_EXE_MEM = 32'h0; RegRdata2_EXE_MEM = 32'h0; RegWaddr_EXE_MEM = 5'h0;
        RegWrite_EXE_MEM = 4'h0; PC_EXE_MEM = 32'h0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_lw_basic();
        test_sb();
        test_swr();
        test_addr_ok_delay();
        test_non_mem();
        test_rst_in_wait();
        test_misaligned();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
